// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the sequencer state encoding and the requester port indices.
package dmem_arbiter_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    // One-hot pulse vector addressing a single requester port.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the memory-side strobes.
// slave = arbiter view, master = requesters and memory view.
interface dmem_arbiter_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [WIDTH-1:0]  wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [WIDTH-1:0]  rdata0;
    logic              err0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [WIDTH-1:0]  wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [WIDTH-1:0]  rdata1;
    logic              err1;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0, err0,
        output gnt1, rvalid1, rdata1, err1,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0, err0,
        input  gnt1, rvalid1, rdata1, err1,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the port granted last gets lowest priority.
// The priority pointer moves only when advance accepts a grant.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant_c
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_c = '0;
        ptr_d   = ptr_q;
        if (req[ptr_q]) begin
            grant_c[ptr_q] = 1'b1;
        end else if (req[~ptr_q]) begin
            grant_c[~ptr_q] = 1'b1;
        end
        // Next priority goes to the port that did not just win.
        if (advance && (|grant_c)) begin
            ptr_d = ~grant_c[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PORT_CORE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer in front of the single-port data memory.
// Serialises core and loader accesses; out-of-range addresses return err.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MEM_NUM = 512,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    state_e                state_q,  state_d;
    logic                  port_q,   port_d;
    logic                  we_q,     we_d;
    logic [ADDR_W-1:0]     addr_q,   addr_d;
    logic [WIDTH-1:0]      wdata_q,  wdata_d;
    logic [NUM_PORTS-1:0]  gnt_q,    gnt_d;
    logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
    logic [NUM_PORTS-1:0]  err_q,    err_d;
    logic [WIDTH-1:0]      rdata0_q, rdata0_d;
    logic [WIDTH-1:0]      rdata1_q, rdata1_d;

    logic [NUM_PORTS-1:0]  grant_c;
    logic                  advance_c;
    logic                  in_range_c;
    logic                  access_ok_c;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({bus.req1, bus.req0}),
        .advance (advance_c),
        .grant_c (grant_c)
    );

    assign in_range_c  = (addr_q < ADDR_W'(MEM_NUM));
    assign access_ok_c = (state_q == ST_ACCESS) && in_range_c;

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_d     = '0;
        rvalid_d  = '0;
        err_d     = '0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        advance_c = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (|grant_c) begin
                    advance_c = 1'b1;
                    port_d    = grant_c[1];
                    gnt_d     = grant_c;
                    state_d   = ST_ACCESS;
                    if (grant_c[1]) begin
                        we_d    = bus.we1;
                        addr_d  = bus.addr1;
                        wdata_d = bus.wdata1;
                    end else begin
                        we_d    = bus.we0;
                        addr_d  = bus.addr0;
                        wdata_d = bus.wdata0;
                    end
                end
            end
            ST_ACCESS: begin
                state_d  = ST_RESP;
                rvalid_d = port_onehot(port_q);
                err_d    = in_range_c ? '0 : port_onehot(port_q);
                // Only reads update the returned data; writes leave it untouched.
                if (!we_q) begin
                    if (port_q == PORT_LOADER) begin
                        rdata1_d = in_range_c ? bus.mem_rdata : '0;
                    end else begin
                        rdata0_d = in_range_c ? bus.mem_rdata : '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            port_q   <= PORT_CORE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.gnt0    = gnt_q[0];
    assign bus.gnt1    = gnt_q[1];
    assign bus.rvalid0 = rvalid_q[0];
    assign bus.rvalid1 = rvalid_q[1];
    assign bus.err0    = err_q[0];
    assign bus.err1    = err_q[1];
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

    // Memory side is decoded from state so strobes line up with the access cycle.
    assign bus.mem_read  = access_ok_c && !we_q;
    assign bus.mem_write = access_ok_c && we_q;
    assign bus.mem_addr  = access_ok_c ? addr_q : '0;
    assign bus.mem_wdata = (access_ok_c && we_q) ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, reference model
// and per-port response scoreboards checked on every rvalid.
module tb_dmem_arbiter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned MEM_NUM = 512;

    typedef struct {
        logic [WIDTH-1:0] rdata;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(.WIDTH(WIDTH), .MEM_NUM(MEM_NUM), .ADDR_W(ADDR_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH-1:0] mem     [MEM_NUM];
    logic [WIDTH-1:0] ref_mem [MEM_NUM];
    logic [WIDTH-1:0] last_rd [2];
    logic             pl_en = 1'b0;
    logic [8:0]       pl_addr = '0;
    logic [WIDTH-1:0] pl_data = '0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    int   checks = 0;
    int   fails = 0;
    int   rd_strobes = 0;
    int   wr_strobes = 0;
    int   rvalid_seen = 0;

    always_comb begin
        bus.mem_rdata = (bus.mem_addr < ADDR_W'(MEM_NUM)) ? mem[bus.mem_addr[8:0]] : '0;
    end

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.mem_write && bus.mem_addr < ADDR_W'(MEM_NUM)) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;
    end

    // Response monitor and invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_read)  rd_strobes++;
            if (bus.mem_write) wr_strobes++;
            if (bus.rvalid0 || bus.rvalid1) rvalid_seen++;
            checks++;
            if ((bus.gnt0 && bus.gnt1) || (bus.rvalid0 && bus.rvalid1) || (bus.mem_read && bus.mem_write)) begin
                fails++;
                $display("FAIL exclusivity: gnt=%b%b rvalid=%b%b rd/wr=%b%b, required at most one of each",
                         bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.mem_read, bus.mem_write);
            end
            if (bus.rvalid0) begin
                checks++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL rvalid0_unexpected: got rvalid0=1, required no pending response");
                end else begin
                    m0 = q0.pop_front();
                    if (bus.rdata0 !== m0.rdata || bus.err0 !== m0.err) begin
                        fails++;
                        $display("FAIL resp0: got rdata0=%h err0=%b, required rdata0=%h err0=%b",
                                 bus.rdata0, bus.err0, m0.rdata, m0.err);
                    end
                end
            end
            if (bus.rvalid1) begin
                checks++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL rvalid1_unexpected: got rvalid1=1, required no pending response");
                end else begin
                    m1 = q1.pop_front();
                    if (bus.rdata1 !== m1.rdata || bus.err1 !== m1.err) begin
                        fails++;
                        $display("FAIL resp1: got rdata1=%h err1=%b, required rdata1=%h err1=%b",
                                 bus.rdata1, bus.err1, m1.rdata, m1.err);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int p, input bit we, input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wdata);
        exp_t e;
        if (addr >= ADDR_W'(MEM_NUM)) begin
            e.err = 1'b1;
            e.rdata = we ? last_rd[p] : '0;
            if (!we) last_rd[p] = '0;
        end else begin
            e.err = 1'b0;
            if (we) begin
                ref_mem[addr[8:0]] = wdata;
                e.rdata = last_rd[p];
            end else begin
                e.rdata = ref_mem[addr[8:0]];
                last_rd[p] = e.rdata;
            end
        end
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive_port(input int p, input bit req, input bit we, input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wdata);
        if (p == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        q0.delete();
        q1.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst_n = 1'b1;
    endtask

    task automatic preload(input int addr, input logic [WIDTH-1:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = 9'(addr); pl_data = data;
        ref_mem[addr] = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One request on one port; returns cycles from req to visible gnt.
    task automatic single_access(input int p, input bit we, input logic [ADDR_W-1:0] addr,
                                 input logic [WIDTH-1:0] wdata, output int lat);
        bit got = 1'b0;
        @(negedge clk);
        drive_port(p, 1'b1, we, addr, wdata);
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if ((p == 0) ? bus.gnt0 : bus.gnt1) got = 1'b1;
        end
        drive_port(p, 1'b0, we, addr, wdata);
        if (got) begin
            push_exp(p, we, addr, wdata);
        end else begin
            checks++;
            fails++;
            $display("FAIL gnt_timeout port%0d: got no gnt in %0d cycles, required gnt", p, lat);
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] ctl_vec();
        return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, bus.mem_read, bus.mem_write};
    endfunction

    task automatic check_all_zero(input string tag);
        checks++;
        if (ctl_vec() !== 8'h00 || bus.rdata0 !== '0 || bus.rdata1 !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            fails++;
            $display("FAIL %s: got ctl=%b rdata0=%h rdata1=%h mem_addr=%h mem_wdata=%h, required all zero",
                     tag, ctl_vec(), bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        check_all_zero("reset_outputs");
    endtask

    task automatic test_write_read();
        int lat;
        int w0, r0;
        w0 = wr_strobes;
        single_access(0, 1'b1, 32'd5, 32'hDEADBEEF, lat);
        checks++;
        if (lat !== 1) begin fails++; $display("FAIL wr_gnt_latency: got %0d, required 1", lat); end
        checks++;
        if (wr_strobes - w0 !== 1) begin fails++; $display("FAIL wr_strobe_count: got %0d, required 1", wr_strobes - w0); end
        r0 = rd_strobes;
        single_access(0, 1'b0, 32'd5, '0, lat);
        checks++;
        if (rd_strobes - r0 !== 1) begin fails++; $display("FAIL rd_strobe_count: got %0d, required 1", rd_strobes - r0); end
        checks++;
        if (bus.rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL rdata0_after_read: got %h, required deadbeef", bus.rdata0); end
    endtask

    task automatic test_simultaneous();
        int g0 = -1, g1 = -1, r0 = -1, r1 = -1;
        apply_reset();
        preload(10, 32'hA0A0_0010);
        preload(11, 32'hB1B1_0011);
        @(negedge clk);
        drive_port(0, 1'b1, 1'b0, 32'd10, '0);
        drive_port(1, 1'b1, 1'b0, 32'd11, '0);
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (bus.gnt0 && g0 < 0) begin g0 = t; bus.req0 = 1'b0; push_exp(0, 1'b0, 32'd10, '0); end
            if (bus.gnt1 && g1 < 0) begin g1 = t; bus.req1 = 1'b0; push_exp(1, 1'b0, 32'd11, '0); end
            if (bus.rvalid0 && r0 < 0) r0 = t;
            if (bus.rvalid1 && r1 < 0) r1 = t;
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        checks++;
        if (g0 !== 1 || g1 !== 3) begin fails++; $display("FAIL simul_gnt_order: got gnt0@%0d gnt1@%0d, required gnt0@1 gnt1@3", g0, g1); end
        checks++;
        if (r0 !== 2 || r1 !== 4) begin fails++; $display("FAIL simul_rvalid_order: got rvalid0@%0d rvalid1@%0d, required 2 and 4", r0, r1); end
    endtask

    task automatic test_back_to_back();
        int n0 = 0, n1 = 0, t = 0;
        int seq[$];
        int gtime[$];
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            preload(100 + i, 32'h1000_0000 + 32'(i));
            preload(200 + i, 32'h2000_0000 + 32'(i));
        end
        @(negedge clk);
        drive_port(0, 1'b1, 1'b0, 32'd100, '0);
        drive_port(1, 1'b1, 1'b0, 32'd200, '0);
        while ((n0 < 8 || n1 < 8) && t < 100) begin
            @(negedge clk);
            t++;
            if (bus.gnt0) begin
                push_exp(0, 1'b0, 32'(100 + n0), '0);
                seq.push_back(0); gtime.push_back(t); n0++;
                if (n0 < 8) bus.addr0 = 32'(100 + n0); else bus.req0 = 1'b0;
            end
            if (bus.gnt1) begin
                push_exp(1, 1'b0, 32'(200 + n1), '0);
                seq.push_back(1); gtime.push_back(t); n1++;
                if (n1 < 8) bus.addr1 = 32'(200 + n1); else bus.req1 = 1'b0;
            end
        end
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        checks++;
        if (seq.size() !== 16 || n0 !== 8 || n1 !== 8) begin
            fails++;
            $display("FAIL b2b_grant_count: got %0d grants (p0=%0d p1=%0d), required 16 (8/8)", seq.size(), n0, n1);
        end
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (seq[i] !== (i % 2)) begin fails++; $display("FAIL b2b_order[%0d]: got port %0d, required port %0d", i, seq[i], i % 2); end
            if (i > 0) begin
                checks++;
                if (gtime[i] - gtime[i-1] !== 2) begin
                    fails++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 2", i, gtime[i] - gtime[i-1]);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat, r0, w0;
        preload(511, 32'hCAFE_01FF);
        r0 = rd_strobes; w0 = wr_strobes;
        single_access(1, 1'b0, 32'd512, '0, lat);
        checks++;
        if (rd_strobes !== r0 || wr_strobes !== w0) begin
            fails++;
            $display("FAIL oor_strobes: got rd=%0d wr=%0d, required none", rd_strobes - r0, wr_strobes - w0);
        end
        checks++;
        if (bus.rdata1 !== '0) begin fails++; $display("FAIL oor_rdata1: got %h, required 0", bus.rdata1); end
        single_access(1, 1'b0, 32'd511, '0, lat);
        checks++;
        if (rd_strobes - r0 !== 1) begin fails++; $display("FAIL edge_addr_strobe: got %0d reads, required 1", rd_strobes - r0); end
    endtask

    task automatic test_reset_mid_access();
        int lat, n = 0, v0;
        bit got = 1'b0;
        @(negedge clk);
        drive_port(0, 1'b1, 1'b1, 32'd20, 32'h7777_0020);
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.gnt0) got = 1'b1;
        end
        checks++;
        if (!got) begin fails++; $display("FAIL mid_reset_gnt: got no gnt0, required gnt0"); end
        rst_n = 1'b0;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        #1;
        check_all_zero("mid_reset_outputs");
        repeat (2) @(negedge clk);
        q0.delete(); q1.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        rst_n = 1'b1;
        v0 = rvalid_seen;
        repeat (4) @(negedge clk);
        checks++;
        if (rvalid_seen !== v0) begin fails++; $display("FAIL mid_reset_no_resp: got %0d rvalid, required 0", rvalid_seen - v0); end
        single_access(0, 1'b0, 32'd5, '0, lat);
        checks++;
        if (lat !== 1) begin fails++; $display("FAIL post_reset_latency: got %0d, required 1", lat); end
    endtask

    task automatic test_rdata_hold();
        int lat;
        preload(30, 32'h0000_1234);
        single_access(0, 1'b0, 32'd30, '0, lat);
        single_access(0, 1'b1, 32'd31, 32'h5555_AAAA, lat);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rdata0 !== 32'h0000_1234) begin fails++; $display("FAIL rdata_hold: got %h, required 00001234", bus.rdata0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_access();
        test_rdata_hold();
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL missing_responses: got %0d/%0d outstanding, required 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
